// File: rtl/multiword_add_sequencer.sv
// rtl/multiword_add_sequencer.sv - word-serial wide adder front end (optional subtract via `MWAS_SUB_EN)
module multiword_add_sequencer #(
  parameter int WIDTH = 32,
  parameter int WORDS = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [WIDTH*WORDS-1:0]   i_in_a,
  input  logic [WIDTH*WORDS-1:0]   i_in_b,
  input  logic                     i_in_cin,
  input  logic                     i_in_sub,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [WIDTH*WORDS-1:0]   o_out_sum,
  output logic                     o_out_cout,
  output logic                     o_out_ovf
);

  localparam int N    = WIDTH * WORDS;
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            r_state;
  logic [IDXW-1:0]   r_idx;
  logic              r_cy;
  logic [N-1:0]      r_a;
  logic [N-1:0]      r_b;
  logic              r_out_valid;
  logic [N-1:0]      r_out_sum;
  logic              r_out_cout;
  logic              r_out_ovf;

  logic [N-1:0]      w_b_eff;
  logic              w_cin_eff;
  logic [WIDTH-1:0]  w_a_word;
  logic [WIDTH-1:0]  w_b_word;
  logic [WIDTH:0]    w_add;
  logic              w_msb_cin;
  logic              w_accept;

  // Operand B and carry-in as they will be stored at capture time
  always_comb begin
    w_b_eff   = i_in_b;
    w_cin_eff = i_in_cin;
`ifdef MWAS_SUB_EN
    if (i_in_sub) begin
      w_b_eff   = ~i_in_b;
      w_cin_eff = 1'b1;
    end
`endif
  end

`ifndef MWAS_SUB_EN
  logic w_unused_sub;
  assign w_unused_sub = i_in_sub;
`endif

  // Current word slice fed to the adder stage, plus carry into the word's MSB for overflow
  always_comb begin
    w_a_word  = r_a[int'(r_idx) * WIDTH +: WIDTH];
    w_b_word  = r_b[int'(r_idx) * WIDTH +: WIDTH];
    w_add     = {1'b0, w_a_word} + {1'b0, w_b_word} + {{WIDTH{1'b0}}, r_cy};
    w_msb_cin = w_a_word[WIDTH-1] ^ w_b_word[WIDTH-1] ^ w_add[WIDTH-1];
  end

  // Ready only in IDLE, and never while reset is held
  assign o_in_ready = (r_state == S_IDLE) && !i_rst;
  assign w_accept   = i_in_valid && o_in_ready;

  // Sequencer FSM: capture, ripple one word per cycle, hold result until taken
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_cy        <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_cout  <= 1'b0;
      r_out_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= i_in_a;
            r_b     <= w_b_eff;
            r_cy    <= w_cin_eff;
            r_idx   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_out_sum[int'(r_idx) * WIDTH +: WIDTH] <= w_add[WIDTH-1:0];
          r_cy <= w_add[WIDTH];
          if (r_idx == LAST_IDX) begin
            r_out_cout  <= w_add[WIDTH];
            r_out_ovf   <= w_msb_cin ^ w_add[WIDTH];
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_sum   = r_out_sum;
  assign o_out_cout  = r_out_cout;
  assign o_out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// tb/tb_multiword_add_sequencer.sv - directed self-checking bench for multiword_add_sequencer
module tb_multiword_add_sequencer;

  localparam int WIDTH = 32;
  localparam int WORDS = 4;
  localparam int N     = WIDTH * WORDS;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_a;
  logic [N-1:0]  in_b;
  logic          in_cin;
  logic          in_sub;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_sum;
  logic          out_cout;
  logic          out_ovf;

  int checks;
  int errors;

  multiword_add_sequencer #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_a      (in_a),
    .i_in_b      (in_b),
    .i_in_cin    (in_cin),
    .i_in_sub    (in_sub),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_sum   (out_sum),
    .o_out_cout  (out_cout),
    .o_out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accept one operand pair, measure latency, check result, then complete the handshake
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                        input logic sub, input logic [N-1:0] exp_sum, input logic exp_cout,
                        input logic exp_ovf, input string name);
    int lat;
    @(negedge clk);
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s accept_ready: got %b want 1", name, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != WORDS) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, WORDS);
    end
    checks++;
    if (out_sum !== exp_sum) begin
      errors++;
      $display("FAIL %s sum: got %h want %h", name, out_sum, exp_sum);
    end
    checks++;
    if (out_cout !== exp_cout) begin
      errors++;
      $display("FAIL %s cout: got %b want %b", name, out_cout, exp_cout);
    end
    checks++;
    if (out_ovf !== exp_ovf) begin
      errors++;
      $display("FAIL %s ovf: got %b want %b", name, out_ovf, exp_ovf);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s post_handshake: got valid=%b ready=%b want valid=0 ready=1",
               name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_sum !== '0 || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b sum=%h cout=%b ovf=%b want all 0",
               out_valid, out_sum, out_cout, out_ovf);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 0", in_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_add();
    run_op({N{1'b1}}, 128'd1, 1'b0, 1'b0, 128'd0, 1'b1, 1'b0, "ripple_all");
    run_op({1'b0, {(N-1){1'b1}}}, 128'd1, 1'b0, 1'b0, {1'b1, {(N-1){1'b0}}}, 1'b0, 1'b1, "signed_ovf");
    run_op(128'd0, 128'd0, 1'b1, 1'b0, 128'd1, 1'b0, 1'b0, "cin_only");
    run_op(128'h0000_0001_FFFF_FFFF_0000_0000_FFFF_FFFF, 128'h0000_0000_0000_0001_0000_0000_0000_0001,
           1'b0, 1'b0, 128'h0000_0002_0000_0000_0000_0001_0000_0000, 1'b0, 1'b0, "mixed_carry");
  endtask

  task automatic test_sub();
`ifdef MWAS_SUB_EN
    run_op(128'd5, 128'd7, 1'b0, 1'b1, {{(N-4){1'b1}}, 4'hE}, 1'b0, 1'b0, "sub_5_7");
`else
    run_op(128'd5, 128'd7, 1'b0, 1'b1, 128'd12, 1'b0, 1'b0, "sub_ignored");
`endif
  endtask

  task automatic test_backpressure();
    int lat;
    @(negedge clk);
    in_a = 128'd10; in_b = 128'd20; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != WORDS) begin
      errors++;
      $display("FAIL bp_latency: got %0d want %0d", lat, WORDS);
    end
    in_a = 128'd100; in_b = 128'd200; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 128'd30 || out_cout !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid=%b sum=%h cout=%b ready=%b want 1/30/0/0",
                 i, out_valid, out_sum, out_cout, in_ready);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got ready=%b valid=%b want 1/0", in_ready, out_valid);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_no_capture: got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
    run_op(128'd100, 128'd200, 1'b0, 1'b0, 128'd300, 1'b0, 1'b0, "bp_second");
  endtask

  task automatic test_reset_mid_run();
    int seen;
    @(negedge clk);
    in_a = {N{1'b1}}; in_b = 128'd1; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_ready: got ready=%b valid=%b want 1/0", in_ready, out_valid);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_output: got %0d valid cycles want 0", seen);
    end
    run_op(128'd3, 128'd4, 1'b0, 1'b0, 128'd7, 1'b0, 1'b0, "after_abort");
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_sub    = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
